pb_led_ctrl: RTL

Parametrised board-I/O controller between the CPU's memory-mapped bus and the push-button and LED pins. For each button it synchronises the input, debounces it and latches rising-edge press events. It also holds an LED output register and drives a level interrupt. It replaces the fixed 5-button / 12-LED wiring with a generic, CPU-readable block.

---
 rtl/pb_led_ctrl_if.sv | 23 ++
 rtl/pb_led_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pb_led_ctrl_if.sv
// CPU-side register bus for pb_led_ctrl: register select, write/read strobes,
// registered read return and the level interrupt.
interface pb_led_ctrl_if;
    logic [1:0]  addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        irq;

    // CPU side drives strobes and consumes read data / interrupt
    modport master (
        output addr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, irq
    );

    // Peripheral side
    modport slave (
        input  addr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, irq
    );
endinterface

// File: rtl/pb_led_ctrl.sv
// pb_led_ctrl: push-button synchroniser/debouncer with sticky press events,
// LED output register and level interrupt behind a 4-register CPU bus.
// Optional LED blinking is built when the macro LED_BLINK_EN is defined.
module pb_led_ctrl #(
    parameter int unsigned NUM_PB     = 5,
    parameter int unsigned LED_W      = 12,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned BLINK_DIV  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PB-1:0] pb,
    output logic [LED_W-1:0]  led,
    pb_led_ctrl_if.slave      bus
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned DW    = 16;

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_EVENT = 2'd1;
    localparam logic [1:0] ADDR_LED   = 2'd2;
    localparam logic [1:0] ADDR_BLINK = 2'd3;

    logic [NUM_PB-1:0]            r_sync1;
    logic [NUM_PB-1:0]            r_sync2;
    logic [NUM_PB-1:0]            r_deb;
    logic [NUM_PB-1:0]            r_deb_d;
    logic [NUM_PB-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_PB-1:0]            r_event;
    logic [LED_W-1:0]             r_led;
    logic [DW-1:0]                r_rd_data;
    logic                         r_rd_valid;

    logic [NUM_PB-1:0]            w_set;
    logic [NUM_PB-1:0]            w_clr;
    logic                         w_wr_event;
    logic                         w_wr_led;
    logic [DW-1:0]                w_rd_mux;

    assign w_wr_event = bus.wr_en && (bus.addr == ADDR_EVENT);
    assign w_wr_led   = bus.wr_en && (bus.addr == ADDR_LED);
    assign w_set      = r_deb & ~r_deb_d;
    assign w_clr      = w_wr_event ? bus.wr_data[NUM_PB-1:0] : '0;

    // Synchronise, debounce and edge-detect every button
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= pb;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < int'(NUM_PB); i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky press flags: a new press in the same cycle beats a W1C clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_event <= '0;
        end else begin
            r_event <= (r_event & ~w_clr) | w_set;
        end
    end

    // LED register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (w_wr_led) begin
            r_led <= bus.wr_data[LED_W-1:0];
        end
    end

`ifdef LED_BLINK_EN
    localparam int unsigned BLK_W = $clog2(BLINK_DIV + 1);

    logic [LED_W-1:0] r_blink;
    logic [BLK_W-1:0] r_div_cnt;
    logic             r_phase;

    // Blink mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink <= '0;
        end else if (bus.wr_en && (bus.addr == ADDR_BLINK)) begin
            r_blink <= bus.wr_data[LED_W-1:0];
        end
    end

    // Free-running phase divider, independent of mask writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (r_div_cnt == BLK_W'(BLINK_DIV - 1)) begin
            r_div_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_div_cnt <= r_div_cnt + BLK_W'(1);
        end
    end

    assign led = r_led & ~(r_blink & {LED_W{r_phase}});
`else
    assign led = r_led;
`endif

    // Read mux over current register contents; unused upper bits read 0
    always_comb begin
        w_rd_mux = '0;
        case (bus.addr)
            ADDR_STATE: w_rd_mux[NUM_PB-1:0] = r_deb;
            ADDR_EVENT: w_rd_mux[NUM_PB-1:0] = r_event;
            ADDR_LED:   w_rd_mux[LED_W-1:0]  = r_led;
`ifdef LED_BLINK_EN
            ADDR_BLINK: w_rd_mux[LED_W-1:0]  = r_blink;
`endif
            default:    w_rd_mux = '0;
        endcase
    end

    // Registered read return, one-cycle latency; data held until next read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.irq      = |r_event;

endmodule
